// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x3 keypad scanner: FSM states,
// full-scan candidate record and the released/error output codes.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    ERROR   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    KEY   = 2'd1,
    MULTI = 2'd2
  } cand_kind_e;

  // row/col are forced to zero for NONE and MULTI so whole-record compares work
  typedef struct packed {
    cand_kind_e kind;
    logic [1:0] row;
    logic [1:3] col;
  } cand_t;

  localparam logic [3:0] ROW_FIRST  = 4'b1000;
  localparam logic [2:0] H_RELEASED = 3'b000;
  localparam logic [3:0] V_RELEASED = 4'b0000;
  localparam logic [2:0] H_ERROR    = 3'b111;
  localparam logic [3:0] V_ERROR    = 4'b1111;

  function automatic logic [3:0] row_onehot(input logic [1:0] idx);
    return ROW_FIRST >> idx;
  endfunction

  function automatic logic is_onehot3(input logic [2:0] p);
    return (p != 3'd0) && ((p & (p - 3'd1)) == 3'd0);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Parameterized-width two-flop synchronizer for asynchronous inputs,
// cleared by an asynchronous active-low reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 keypad front end: row strobe, synchronized column sampling, per-scan
// candidate classification, debounce and a registered one-hot h/v code.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:3] col_in,
  output logic [1:4] row_drive,
  output logic [1:3] h,
  output logic [1:4] v,
  output logic       key_valid
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);

  logic [1:3]    col_s;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:4]    row_drive_q, row_drive_d;
  logic [1:0]    row_idx_q, row_idx_d;
  logic [1:0]    hits_q, hits_d;
  logic [1:0]    last_row_q, last_row_d;
  logic [1:3]    last_col_q, last_col_d;
  cand_t         prev_q, prev_d;
  cand_t         acc_q, acc_d;
  logic [SW-1:0] stable_q, stable_d;
  state_e        state_q, state_d;
  logic [1:3]    h_q, h_d;
  logic [1:4]    v_q, v_d;
  logic          key_valid_q, key_valid_d;

  logic          tc;
  logic          scan_done;
  logic          row_hit;
  logic [1:0]    hits_tot;
  logic [1:0]    tot_row;
  logic [1:3]    tot_col;
  cand_t         cand;
  logic [SW-1:0] stable_inc;
  logic          accept;

  sync_2ff #(.WIDTH(3)) u_col_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (col_in),
    .q     (col_s)
  );

  assign tc        = (dwell_q == DW'(SCAN_DIV - 1));
  assign scan_done = tc && (row_idx_q == 2'd3);

  // Row strobe: dwell SCAN_DIV cycles per row, sample on the terminal count.
  always_comb begin
    dwell_d     = dwell_q + DW'(1);
    row_drive_d = row_drive_q;
    row_idx_d   = row_idx_q;
    if (tc) begin
      dwell_d     = '0;
      row_drive_d = {row_drive_q[4], row_drive_q[1:3]};
      row_idx_d   = row_idx_q + 2'd1;
    end
  end

  // Fold the current row sample into the scan record; hit count saturates at 2.
  always_comb begin
    row_hit  = |col_s;
    hits_tot = hits_q;
    if (row_hit && (hits_q != 2'd2)) hits_tot = hits_q + 2'd1;
    tot_row = row_hit ? row_idx_q : last_row_q;
    tot_col = row_hit ? col_s : last_col_q;

    cand.kind = NONE;
    cand.row  = 2'd0;
    cand.col  = 3'b000;
    if ((hits_tot == 2'd1) && is_onehot3(tot_col)) begin
      cand.kind = KEY;
      cand.row  = tot_row;
      cand.col  = tot_col;
    end else if (hits_tot != 2'd0) begin
      cand.kind = MULTI;
    end

    hits_d     = hits_q;
    last_row_d = last_row_q;
    last_col_d = last_col_q;
    if (scan_done) begin
      hits_d     = 2'd0;
      last_row_d = 2'd0;
      last_col_d = 3'b000;
    end else if (tc) begin
      hits_d     = hits_tot;
      last_row_d = tot_row;
      last_col_d = tot_col;
    end
  end

  always_comb begin
    if (cand == prev_q) begin
      stable_inc = (stable_q == SW'(DEBOUNCE_SCANS)) ? stable_q : stable_q + SW'(1);
    end else begin
      stable_inc = SW'(1);
    end
    accept   = scan_done && (stable_inc == SW'(DEBOUNCE_SCANS)) && (cand != acc_q);
    stable_d = scan_done ? stable_inc : stable_q;
    prev_d   = scan_done ? cand : prev_q;
    acc_d    = accept ? cand : acc_q;
  end

  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    v_d         = v_q;
    key_valid_d = 1'b0;
    if (accept) begin
      unique case (cand.kind)
        NONE:    state_d = IDLE;
        KEY:     state_d = PRESSED;
        default: state_d = ERROR;
      endcase
      unique case (state_d)
        IDLE: begin
          h_d = H_RELEASED;
          v_d = V_RELEASED;
        end
        PRESSED: begin
          h_d         = cand.col;
          v_d         = row_onehot(cand.row);
          key_valid_d = 1'b1;
        end
        default: begin
          h_d = H_ERROR;
          v_d = V_ERROR;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dwell_q     <= '0;
      row_drive_q <= ROW_FIRST;
      row_idx_q   <= 2'd0;
      hits_q      <= 2'd0;
      last_row_q  <= 2'd0;
      last_col_q  <= 3'b000;
      prev_q      <= '{kind: NONE, row: 2'd0, col: 3'b000};
      acc_q       <= '{kind: NONE, row: 2'd0, col: 3'b000};
      stable_q    <= '0;
      state_q     <= IDLE;
      h_q         <= H_RELEASED;
      v_q         <= V_RELEASED;
      key_valid_q <= 1'b0;
    end else begin
      dwell_q     <= dwell_d;
      row_drive_q <= row_drive_d;
      row_idx_q   <= row_idx_d;
      hits_q      <= hits_d;
      last_row_q  <= last_row_d;
      last_col_q  <= last_col_d;
      prev_q      <= prev_d;
      acc_q       <= acc_d;
      stable_q    <= stable_d;
      state_q     <= state_d;
      h_q         <= h_d;
      v_q         <= v_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign row_drive = row_drive_q;
  assign h         = h_q;
  assign v         = v_q;
  assign key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad matrix model turns pressed keys
// into column returns from row_drive; each scenario checks h/v/key_valid inline.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:3] col_in;
  logic [1:4] row_drive;
  logic [1:3] h;
  logic [1:4] v;
  logic       key_valid;

  logic        raw_en;
  logic [1:3]  raw_col;
  logic [11:0] keys;   // bit (row-1)*3 + (col-1)

  int checks = 0;
  int errors = 0;

  localparam int K1 = 0;
  localparam int K5 = 4;
  localparam int K9 = 8;
  localparam int K0 = 10;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .col_in    (col_in),
    .row_drive (row_drive),
    .h         (h),
    .v         (v),
    .key_valid (key_valid)
  );

  always #5 clk = ~clk;

  always_comb begin
    col_in = 3'b000;
    if (raw_en) begin
      col_in = raw_col;
    end else begin
      for (int r = 1; r <= 4; r++)
        for (int c = 1; c <= 3; c++)
          if (row_drive[r] && keys[(r-1)*3 + (c-1)]) col_in[c] = 1'b1;
    end
  end

  task automatic test_reset();
    logic [3:0] exp_row;
    raw_en  = 1'b1;
    raw_col = 3'b101;
    keys    = '0;
    reset   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({row_drive, h, v, key_valid} !== {4'b1000, 3'b000, 4'b0000, 1'b0}) begin
        errors++;
        $display("FAIL reset_hold[%0d]: row=%b h=%b v=%b kv=%b, want row=1000 h=000 v=0000 kv=0",
                 i, row_drive, h, v, key_valid);
      end
    end
    reset  = 1'b1;
    raw_en = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      exp_row = 4'b1000 >> ((i / 4) % 4);
      checks++;
      if (row_drive !== exp_row) begin
        errors++;
        $display("FAIL row_rotate[%0d]: got %b want %b", i, row_drive, exp_row);
      end
    end
  endtask

  task automatic test_single_key();
    int first;
    int pulses;
    keys = '0;
    keys[K5] = 1'b1;
    first = -1;
    pulses = 0;
    for (int i = 1; i <= 150; i++) begin
      @(negedge clk);
      if (key_valid) pulses++;
      if (first < 0 && h == 3'b010 && v == 4'b0100) first = i;
    end
    checks++;
    if (first < 0 || first > 67) begin
      errors++;
      $display("FAIL key5_latency: got %0d cycles want 1..67", first);
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL key5_pulses: got %0d want 1", pulses);
    end
    checks++;
    if ({h, v} !== {3'b010, 4'b0100}) begin
      errors++;
      $display("FAIL key5_code: got %b/%b want 010/0100", h, v);
    end
    keys = '0;
    first = -1;
    pulses = 0;
    for (int i = 1; i <= 150; i++) begin
      @(negedge clk);
      if (key_valid) pulses++;
      if (first < 0 && h == 3'b000 && v == 4'b0000) first = i;
    end
    checks++;
    if (first < 0 || first > 67) begin
      errors++;
      $display("FAIL key5_release_latency: got %0d cycles want 1..67", first);
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL key5_release_pulses: got %0d want 0", pulses);
    end
  endtask

  task automatic test_bounce();
    logic [1:4] prev;
    logic       found;
    int         bad;
    int         pulses;
    int         accepted_at;
    keys  = '0;
    found = 1'b0;
    prev  = row_drive;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (row_drive == 4'b1000 && prev == 4'b0001) found = 1'b1;
      prev = row_drive;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL bounce_align: got no scan start want one within 40 cycles");
    end
    repeat (11) @(negedge clk);
    bad = 0;
    pulses = 0;
    for (int b = 0; b < 60; b++) begin
      keys[K1] = ((b / 7) % 2) == 0;
      @(negedge clk);
      if (h !== 3'b000 || v !== 4'b0000) bad++;
      if (key_valid) pulses++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL bounce_quiet: got %0d non-released cycles want 0", bad);
    end
    keys[K1] = 1'b1;
    accepted_at = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (key_valid) pulses++;
      if (accepted_at < 0 && h == 3'b100 && v == 4'b1000) accepted_at = i;
    end
    checks++;
    if (accepted_at < 32 || accepted_at > 67) begin
      errors++;
      $display("FAIL bounce_accept_time: got %0d cycles after steady want 32..67", accepted_at);
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL bounce_pulses: got %0d want 1", pulses);
    end
    keys = '0;
    repeat (80) @(negedge clk);
    checks++;
    if ({h, v} !== 7'b0) begin
      errors++;
      $display("FAIL bounce_release: got %b/%b want 000/0000", h, v);
    end
  endtask

  task automatic test_multi();
    int first;
    int pulses;
    keys = '0;
    keys[K1] = 1'b1;
    keys[K0] = 1'b1;
    first = -1;
    pulses = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (key_valid) pulses++;
      if (first < 0 && h == 3'b111 && v == 4'b1111) first = i;
    end
    checks++;
    if (first < 0 || first > 67) begin
      errors++;
      $display("FAIL multi_error_code: reached after %0d cycles (h=%b v=%b) want 111/1111 within 67",
               first, h, v);
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL multi_pulses: got %0d want 0", pulses);
    end
    keys = '0;
    pulses = 0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (key_valid) pulses++;
    end
    checks++;
    if ({h, v, pulses} !== {3'b000, 4'b0000, 32'd0}) begin
      errors++;
      $display("FAIL multi_release: got %b/%b pulses=%0d want 000/0000 pulses=0", h, v, pulses);
    end
  endtask

  task automatic test_sequence();
    int         kidx  [4] = '{K1, K1, K0, K5};
    logic [6:0] kcode [4] = '{7'b100_1000, 7'b100_1000, 7'b010_0001, 7'b010_0100};
    int         pulses;
    logic [6:0] seen;
    for (int j = 0; j < 4; j++) begin
      keys = '0;
      keys[kidx[j]] = 1'b1;
      pulses = 0;
      seen = 7'b0;
      for (int i = 0; i < 80; i++) begin
        @(negedge clk);
        if (key_valid) begin
          pulses++;
          seen = {h, v};
        end
      end
      checks++;
      if (pulses !== 1) begin
        errors++;
        $display("FAIL seq%0d_pulses: got %0d want 1", j, pulses);
      end
      checks++;
      if (seen !== kcode[j]) begin
        errors++;
        $display("FAIL seq%0d_code: got %b want %b", j, seen, kcode[j]);
      end
      keys = '0;
      pulses = 0;
      for (int i = 0; i < 80; i++) begin
        @(negedge clk);
        if (key_valid) pulses++;
      end
      checks++;
      if (pulses !== 0) begin
        errors++;
        $display("FAIL seq%0d_release_pulses: got %0d want 0", j, pulses);
      end
      checks++;
      if ({h, v} !== 7'b0) begin
        errors++;
        $display("FAIL seq%0d_release_code: got %b/%b want 000/0000", j, h, v);
      end
    end
  endtask

  task automatic test_reset_mid_press();
    int first;
    int pulses;
    keys = '0;
    keys[K9] = 1'b1;
    first = -1;
    for (int i = 1; i <= 80 && first < 0; i++) begin
      @(negedge clk);
      if (h == 3'b001 && v == 4'b0010) first = i;
    end
    checks++;
    if (first < 0) begin
      errors++;
      $display("FAIL key9_accept: got h=%b v=%b want 001/0010 within 80 cycles", h, v);
    end
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({row_drive, h, v, key_valid} !== {4'b1000, 3'b000, 4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL async_clear: row=%b h=%b v=%b kv=%b want 1000/000/0000/0",
               row_drive, h, v, key_valid);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({h, v, key_valid} !== 8'b0) begin
      errors++;
      $display("FAIL reset_held_clear: h=%b v=%b kv=%b want 000/0000/0", h, v, key_valid);
    end
    reset = 1'b1;
    first = -1;
    pulses = 0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (key_valid) pulses++;
      if (first < 0 && h == 3'b001 && v == 4'b0010) first = i;
    end
    checks++;
    if (first < 0 || first > 67) begin
      errors++;
      $display("FAIL key9_reappear: got %0d cycles want 1..67", first);
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL key9_repulse: got %0d want 1", pulses);
    end
    keys = '0;
    repeat (80) @(negedge clk);
    checks++;
    if ({h, v} !== 7'b0) begin
      errors++;
      $display("FAIL key9_release: got %b/%b want 000/0000", h, v);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    raw_en  = 1'b0;
    raw_col = 3'b000;
    keys    = '0;
    reset   = 1'b0;
    test_reset();
    test_single_key();
    test_bounce();
    test_multi();
    test_sequence();
    test_reset_mid_press();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
